// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   REG_ADDR_W  : width of a register address
//   NUM_REGS    : number of architectural registers
//   REG_PC      : address of the PC register (R15). The register file reloads it every cycle.
//   arb_state_t : round-robin priority state for contended grants
//   pend_onehot : one-hot pending bit for an address. R15 never shows as pending.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam logic [REG_ADDR_W-1:0] REG_PC = 4'hF;

    typedef enum logic {PRI0, PRI1} arb_state_t;

    function automatic logic [NUM_REGS-1:0] pend_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (addr != REG_PC) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the write-back requesters and the arbiter.
//   req0_* / req1_*  : valid/ready write requests (addr, data)
//   we3 / a3 / wd3   : register file write port
//   pend_mask        : registers with a write held in a slot
//   r15_drop         : pulse when a held R15 write is retired without writing
//   busy             : at least one slot is full
// Modports:
//   master : requester and register-file side
//   slave  : arbiter side
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int N = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_addr;
    logic [N-1:0]          req0_data;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_addr;
    logic [N-1:0]          req1_data;
    logic                  we3;
    logic [REG_ADDR_W-1:0] a3;
    logic [N-1:0]          wd3;
    logic [NUM_REGS-1:0]   pend_mask;
    logic                  r15_drop;
    logic                  busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we3, a3, wd3, pend_mask, r15_drop, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we3, a3, wd3, pend_mask, r15_drop, busy
    );

endinterface

// File: rtl/regfile_wb_slot.sv
// One-entry holding buffer for a write-back request.
//   clk, rst            : clock and synchronous active-low reset
//   in_valid/in_ready   : accept handshake. Ready is also high while the entry is being retired.
//   in_addr/in_data     : captured when in_valid && in_ready
//   retire              : the arbiter is consuming the held entry this cycle
//   load                : accept strobe, used for age and pending tracking
//   full/addr/data      : held entry
module wb_slot
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_addr,
    input  logic [N-1:0]          in_data,
    input  logic                  retire,
    output logic                  load,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] addr,
    output logic [N-1:0]          data
);

    logic                  full_reg;
    logic [REG_ADDR_W-1:0] addr_reg;
    logic [N-1:0]          data_reg;

    // Accepting while the entry is retired gives one transfer per cycle.
    assign in_ready = !full_reg || retire;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (load) begin
            full_reg <= 1'b1;
            addr_reg <= in_addr;
            data_reg <= in_data;
        end else if (retire) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign addr = addr_reg;
    assign data = data_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between two write-back requesters.
// Each requester has one holding slot. At most one slot is retired per cycle.
// Grant order:
//   - a lone full slot is granted;
//   - same-address pairs are granted oldest first, and slot 0 wins a tie;
//   - other pairs are granted by a round-robin state.
// Writes to the PC register are dropped, and r15_drop pulses when that happens.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : requester handshakes, register-file write port, pend_mask/r15_drop/busy
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    typedef struct packed {
        logic                  full;
        logic [REG_ADDR_W-1:0] addr;
        logic [N-1:0]          data;
    } wb_slot_t;

    wb_slot_t              slot      [NREQ];
    logic [NREQ-1:0]       in_valid;
    logic [NREQ-1:0]       in_ready;
    logic [NREQ-1:0]       load;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       slot_full;
    logic [REG_ADDR_W-1:0] in_addr   [NREQ];
    logic [N-1:0]          in_data   [NREQ];
    logic [REG_ADDR_W-1:0] slot_addr [NREQ];
    logic [N-1:0]          slot_data [NREQ];

    arb_state_t            state_reg;
    logic                  age_reg;       // 1: slot 1 holds the older entry
    logic                  age_next;
    logic [NUM_REGS-1:0]   pend_reg;
    logic [NUM_REGS-1:0]   pend_next;

    logic                  both_full;
    logic                  same_addr;
    logic                  contended;
    logic                  grant_any;
    logic                  grant_sel;
    logic [REG_ADDR_W-1:0] grant_addr;
    logic [N-1:0]          grant_data;
    logic [NREQ-1:0]       next_full;
    logic [REG_ADDR_W-1:0] next_addr [NREQ];

    assign in_valid[0]    = bus.req0_valid;
    assign in_valid[1]    = bus.req1_valid;
    assign in_addr[0]     = bus.req0_addr;
    assign in_addr[1]     = bus.req1_addr;
    assign in_data[0]     = bus.req0_data;
    assign in_data[1]     = bus.req1_data;
    assign bus.req0_ready = in_ready[0];
    assign bus.req1_ready = in_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            wb_slot #(.N(N)) u_slot (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .in_addr  (in_addr[gi]),
                .in_data  (in_data[gi]),
                .retire   (grant[gi]),
                .load     (load[gi]),
                .full     (slot_full[gi]),
                .addr     (slot_addr[gi]),
                .data     (slot_data[gi])
            );

            assign slot[gi] = {slot_full[gi], slot_addr[gi], slot_data[gi]};

            // Slot contents after this edge. These feed the registered pending mask.
            assign next_full[gi] = load[gi] || (slot[gi].full && !grant[gi]);
            assign next_addr[gi] = load[gi] ? in_addr[gi] : slot[gi].addr;
        end
    endgenerate

    // The grant depends only on slot flops and arbiter state.
    // This keeps the request valids off any path to the write port.
    always_comb begin
        both_full = slot[0].full && slot[1].full;
        same_addr = slot[0].addr == slot[1].addr;
        contended = both_full && !same_addr;
        grant     = '0;
        if (both_full) begin
            if (same_addr) begin
                grant = age_reg ? 2'b10 : 2'b01;
            end else begin
                grant = (state_reg == PRI0) ? 2'b01 : 2'b10;
            end
        end else begin
            grant = {slot[1].full, slot[0].full};
        end
        grant_any  = |grant;
        grant_sel  = grant[1];
        grant_addr = slot[grant_sel].addr;
        grant_data = slot[grant_sel].data;
    end

    always_comb begin
        bus.we3      = grant_any && (grant_addr != REG_PC);
        bus.r15_drop = grant_any && (grant_addr == REG_PC);
        bus.a3       = bus.we3 ? grant_addr : '0;
        bus.wd3      = bus.we3 ? grant_data : '0;
    end

    // The age flag is only meaningful while both slots hold entries.
    // It names the slot whose entry survived the edge while the other slot was loaded.
    always_comb begin
        age_next = 1'b0;
        if (next_full[0] && next_full[1]) begin
            if (load[0] && !load[1]) begin
                age_next = 1'b1;
            end else if (load[1] && !load[0]) begin
                age_next = 1'b0;
            end else if (load[0] && load[1]) begin
                age_next = 1'b0;
            end else begin
                age_next = age_reg;
            end
        end
    end

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (next_full[i]) begin
                pend_next = pend_next | pend_onehot(next_addr[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= PRI0;
            age_reg   <= 1'b0;
            pend_reg  <= '0;
        end else begin
            age_reg  <= age_next;
            pend_reg <= pend_next;
            // Only a different-address pair moves the round-robin pointer.
            if (contended) begin
                state_reg <= (state_reg == PRI0) ? PRI1 : PRI0;
            end
            assert ($onehot0(grant));
            assert (!(bus.we3 && bus.r15_drop));
        end
    end

    assign bus.pend_mask = pend_reg;
    assign bus.busy      = |slot_full;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.N(N)) bus ();

    regfile_wb_arbiter #(.N(N), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: two slots with load timestamps and a round-robin pointer.
    bit          m_full  [2];
    logic [3:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    int          rr_next;
    int          cyc;
    bit          acc     [2];
    logic [31:0] exp_rf  [16];
    logic [31:0] obs_rf  [16];
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) return (m_stamp[1] < m_stamp[0]) ? 1 : 0;
            return rr_next;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i]  = 1'b0;
            m_stamp[i] = 0;
        end
        rr_next = 0;
    endtask

    task automatic compare_outputs();
        int          g;
        logic        e_we;
        logic        e_drop;
        logic [3:0]  e_a3;
        logic [31:0] e_wd;
        logic [15:0] e_pend;
        g      = model_grant();
        e_we   = (g >= 0) && (m_addr[g] != 4'hF);
        e_drop = (g >= 0) && (m_addr[g] == 4'hF);
        e_a3   = e_we ? m_addr[g] : 4'h0;
        e_wd   = e_we ? m_data[g] : 32'h0;
        e_pend = '0;
        for (int i = 0; i < 2; i++) begin
            if (m_full[i] && m_addr[i] != 4'hF) e_pend[m_addr[i]] = 1'b1;
        end
        chk("we3",        {31'b0, bus.we3},        {31'b0, e_we});
        chk("a3",         {28'b0, bus.a3},         {28'b0, e_a3});
        chk("wd3",        bus.wd3,                 e_wd);
        chk("r15_drop",   {31'b0, bus.r15_drop},   {31'b0, e_drop});
        chk("pend_mask",  {16'b0, bus.pend_mask},  {16'b0, e_pend});
        chk("busy",       {31'b0, bus.busy},       {31'b0, m_full[0] | m_full[1]});
        chk("req0_ready", {31'b0, bus.req0_ready}, {31'b0, !m_full[0] || g == 0});
        chk("req1_ready", {31'b0, bus.req1_ready}, {31'b0, !m_full[1] || g == 1});
    endtask

    // Run one clock.
    // Inputs are already driven. Outputs are checked before the edge.
    // The model then advances, and the task returns at the following negedge.
    task automatic step();
        int          g;
        bit          v   [2];
        logic [3:0]  a   [2];
        logic [31:0] d   [2];
        bit          rst_s;
        compare_outputs();
        g = model_grant();
        if (bus.we3) begin
            obs_rf[bus.a3] = bus.wd3;
            $display("cycle %0d: write r%0d <= %h", cyc, bus.a3, bus.wd3);
        end
        if (bus.r15_drop) $display("cycle %0d: r15 write dropped", cyc);
        v[0] = bus.req0_valid; a[0] = bus.req0_addr; d[0] = bus.req0_data;
        v[1] = bus.req1_valid; a[1] = bus.req1_addr; d[1] = bus.req1_data;
        rst_s = rst;
        for (int i = 0; i < 2; i++) acc[i] = v[i] && (!m_full[i] || g == i);
        @(posedge clk);
        if (g >= 0 && m_addr[g] != 4'hF) exp_rf[m_addr[g]] = m_data[g];
        if (!rst_s) begin
            model_reset();
            acc[0] = 1'b0;
            acc[1] = 1'b0;
        end else begin
            if (g >= 0) begin
                if (m_full[0] && m_full[1] && m_addr[0] != m_addr[1]) rr_next = 1 - rr_next;
                m_full[g] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    m_full[i]  = 1'b1;
                    m_addr[i]  = a[i];
                    m_data[i]  = d[i];
                    m_stamp[i] = cyc;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input int idx, input bit v, input logic [3:0] a, input logic [31:0] d);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
        end
    endtask

    function automatic logic [3:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 3) return 4'hF;
        if (r < 10) return 4'($urandom_range(0, 2));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < 16; i++) begin
            exp_rf[i] = '0;
            obs_rf[i] = '0;
        end
        model_reset();
        drive(0, 1'b0, 4'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 32'h0);

        // Reset, then idle.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we3",    {31'b0, bus.we3},        32'h0);
        chk("rst_pend",   {16'b0, bus.pend_mask},  32'h0);
        chk("rst_ready0", {31'b0, bus.req0_ready}, 32'h1);
        chk("rst_ready1", {31'b0, bus.req1_ready}, 32'h1);
        chk("rst_busy",   {31'b0, bus.busy},       32'h0);
        rst = 1'b1;
        step();

        // Single write.
        drive(0, 1'b1, 4'd3, 32'hDEADBEEF);
        step();
        drive(0, 1'b0, 4'd0, 32'h0);
        chk("single_we3",  {31'b0, bus.we3},       32'h1);
        chk("single_a3",   {28'b0, bus.a3},        32'h3);
        chk("single_wd3",  bus.wd3,                32'hDEADBEEF);
        chk("single_pend", {16'b0, bus.pend_mask}, 32'h0008);
        step();
        chk("single_we3_after",  {31'b0, bus.we3},       32'h0);
        chk("single_pend_after", {16'b0, bus.pend_mask}, 32'h0);

        // Contention on different addresses. The second round starts from PRI1.
        for (int round = 0; round < 2; round++) begin
            drive(0, 1'b1, 4'd1, 32'h11);
            drive(1, 1'b1, 4'd2, 32'h22);
            step();
            drive(0, 1'b0, 4'd0, 32'h0);
            drive(1, 1'b0, 4'd0, 32'h0);
            chk("cont_first_a3",  {28'b0, bus.a3}, (round == 0) ? 32'h1 : 32'h2);
            chk("cont_first_wd3", bus.wd3,         (round == 0) ? 32'h11 : 32'h22);
            step();
            chk("cont_second_a3", {28'b0, bus.a3}, (round == 0) ? 32'h2 : 32'h1);
            step();
        end

        // Same-address ordering. Slot 1 loses to slot 0 and stalls, then slot 0 reloads addr 5.
        drive(0, 1'b1, 4'd7, 32'h77);
        drive(1, 1'b1, 4'd5, 32'hA);
        step();
        chk("age_pre_a3", {28'b0, bus.a3}, 32'h7);
        drive(0, 1'b1, 4'd5, 32'hB);
        drive(1, 1'b0, 4'd0, 32'h0);
        step();
        drive(0, 1'b0, 4'd0, 32'h0);
        chk("age_old_a3",  {28'b0, bus.a3}, 32'h5);
        chk("age_old_wd3", bus.wd3,         32'hA);
        step();
        chk("age_new_a3",  {28'b0, bus.a3}, 32'h5);
        chk("age_new_wd3", bus.wd3,         32'hB);
        step();
        chk("age_final_r5", obs_rf[5], 32'hB);

        // Write to R15 is dropped.
        drive(1, 1'b1, 4'hF, 32'h1234);
        step();
        drive(1, 1'b0, 4'd0, 32'h0);
        chk("r15_drop",   {31'b0, bus.r15_drop},  32'h1);
        chk("r15_we3",    {31'b0, bus.we3},       32'h0);
        chk("r15_pend15", {31'b0, bus.pend_mask[15]}, 32'h0);
        chk("r15_busy",   {31'b0, bus.busy},      32'h1);
        step();
        chk("r15_drop_after", {31'b0, bus.r15_drop}, 32'h0);

        // Reset while both slots are full.
        drive(0, 1'b1, 4'd3, 32'h33);
        drive(1, 1'b1, 4'd4, 32'h44);
        step();
        drive(0, 1'b0, 4'd0, 32'h0);
        drive(1, 1'b0, 4'd0, 32'h0);
        chk("mid_busy", {31'b0, bus.busy},      32'h1);
        chk("mid_pend", {16'b0, bus.pend_mask}, 32'h0018);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_we3",  {31'b0, bus.we3},       32'h0);
        chk("mid_rst_busy", {31'b0, bus.busy},      32'h0);
        chk("mid_rst_pend", {16'b0, bus.pend_mask}, 32'h0);
        chk("mid_rst_rdy1", {31'b0, bus.req1_ready}, 32'h1);
        step();
        chk("mid_rst_we3_after", {31'b0, bus.we3}, 32'h0);

        // Randomized traffic. A request left pending is held unchanged until it is accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                bit hold;
                hold = (i == 0) ? (bus.req0_valid && !acc[0]) : (bus.req1_valid && !acc[1]);
                if (!hold || !rst) begin
                    drive(i, ($urandom_range(0, 99) < 60), rand_addr(), $urandom());
                end
            end
            rst = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1'b1;
        drive(0, 1'b0, 4'd0, 32'h0);
        drive(1, 1'b0, 4'd0, 32'h0);
        repeat (4) step();

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("rf_r%0d", i), obs_rf[i], exp_rf[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
